// File: rtl/img_pkg.sv
// img_pkg: shared state encoding and pixel widths for the grayscale frame path
package img_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, FILL, ACTIVE, DONE} rd_state_t;
    localparam int GRAY_W = 12;
    localparam int VGA_W  = 10;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y position of the next pixel to be served in the active area
module raster_counter #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        adv,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        last
);
    assign last = (x == 11'(H_ACT - 1)) && (y == 10'(V_ACT - 1));
    // advance column, wrap to next line at end of line and to top after the last line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            x <= (x == 11'(H_ACT - 1)) ? '0 : x + 11'd1;
            y <= (x != 11'(H_ACT - 1)) ? y : last ? '0 : y + 10'd1;
        end
    end
endmodule

// File: rtl/gray_frame_reader.sv
// gray_frame_reader: streams one grayscale frame from the SDRAM read FIFO to the VGA controller
module gray_frame_reader
    import img_pkg::*;
#(
    parameter int               H_ACT     = 640,
    parameter int               V_ACT     = 480,
    parameter int               ADDR_W    = 23,
    parameter int               BASE_ADDR = 0,
    parameter logic [7:0]       BURST_LEN = 8'd128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              vga_req,
    input  logic [15:0]       rd_data,
    input  logic              rd_empty,
    output logic              rd,
    output logic              rd_load,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_max_addr,
    output logic [7:0]        rd_length,
    output logic [VGA_W-1:0]  vga_r,
    output logic [VGA_W-1:0]  vga_g,
    output logic [VGA_W-1:0]  vga_b,
    output logic              pix_valid,
    output logic [10:0]       pix_x,
    output logic [9:0]        pix_y,
    output logic              underflow
);
    rd_state_t          r_state, w_next;
    logic               w_accept, w_uf_set, w_last, w_unused;
    logic               r_rd_load, r_p1_valid, r_p1_fifo, r_pix_valid, r_underflow;
    logic [VGA_W-1:0]   r_pix;

    assign w_accept    = vga_req && (r_state == ACTIVE) && !frame_start;
    assign rd          = w_accept && !rd_empty;
    assign w_uf_set    = (w_accept && rd_empty) || (vga_req && (r_state == FILL) && !frame_start);
    assign rd_addr     = ADDR_W'(BASE_ADDR);
    assign rd_max_addr = ADDR_W'(BASE_ADDR + H_ACT * V_ACT);
    assign rd_length   = BURST_LEN;
    assign rd_load     = r_rd_load;
    assign vga_r       = r_pix;
    assign vga_g       = r_pix;
    assign vga_b       = r_pix;
    assign pix_valid   = r_pix_valid;
    assign underflow   = r_underflow;
    assign w_unused    = &{1'b0, rd_data[15:GRAY_W], rd_data[GRAY_W-VGA_W-1:0]};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: frame_start restarts the frame from any state
    always_comb begin
        w_next = r_state;
        w_next = frame_start                     ? LOAD   :
                 (r_state == LOAD)               ? FILL   :
                 (r_state == FILL && !rd_empty)  ? ACTIVE :
                 (w_accept && w_last)            ? DONE   : r_state;
    end

    // reload pulse coincides with the single LOAD cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_load <= 1'b0;
        else        r_rd_load <= frame_start;
    end

    // two-stage pixel pipeline; the fifo bit selects FIFO data or black when data arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_valid  <= 1'b0;
            r_p1_fifo   <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix       <= '0;
        end else begin
            r_p1_valid  <= vga_req;
            r_p1_fifo   <= rd;
            r_pix_valid <= r_p1_valid;
            r_pix       <= r_p1_fifo ? rd_data[GRAY_W-1 -: VGA_W] : '0;
        end
    end

    // sticky underflow, cleared when a new frame is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_underflow <= 1'b0;
        else if (r_state == LOAD)  r_underflow <= 1'b0;
        else if (w_uf_set)         r_underflow <= 1'b1;
    end

    raster_counter #(.H_ACT(H_ACT), .V_ACT(V_ACT)) u_raster (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (r_state == LOAD),
        .adv  (w_accept),
        .x    (pix_x),
        .y    (pix_y),
        .last (w_last)
    );
endmodule

// File: tb/tb_gray_frame_reader.sv
// tb_gray_frame_reader: randomized scoreboard bench against a frame-level reference model
module tb_gray_frame_reader;
    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 0, rst_n = 1, frame_start = 0, vga_req = 0, rd_empty = 1;
    logic [15:0] rd_data = 0;
    logic        rd, rd_load, pix_valid, underflow;
    logic [22:0] rd_addr, rd_max_addr;
    logic [7:0]  rd_length;
    logic [9:0]  vga_r, vga_g, vga_b, pix_y;
    logic [10:0] pix_x;

    int          total = 0, bad = 0;
    logic [9:0]  exp_q[$];
    int          m_mode = 0;
    int          m_n = 0;
    bit          m_uf = 0;
    logic [15:0] nxt_d = 0;

    gray_frame_reader #(.H_ACT(H), .V_ACT(V)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .vga_req(vga_req),
        .rd_data(rd_data), .rd_empty(rd_empty), .rd(rd), .rd_load(rd_load),
        .rd_addr(rd_addr), .rd_max_addr(rd_max_addr), .rd_length(rd_length),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: every presented pixel is matched against the oldest outstanding request
    always @(negedge clk) begin : mon
        logic [9:0] e;
        if (rst_n && pix_valid) begin
            if (exp_q.size() == 0) chk("unexpected_pixel", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("pix_r", vga_r, e);
                chk("pix_g", vga_g, e);
                chk("pix_b", vga_b, e);
            end
        end
    end

    // model modes: 0 idle, 1 load, 2 wait for data, 3 streaming, 4 frame complete
    task automatic cycle(bit req, bit fs, bit empty, int dsel);
        logic [15:0] d;
        bit acc, srv, ufs;
        int pre;
        vga_req = req; frame_start = fs; rd_empty = empty; rd_data = nxt_d;
        pre = m_mode;
        acc = req && pre == 3 && !fs;
        srv = acc && !empty;
        ufs = (acc && empty) || (req && pre == 2 && !fs);
        d = (dsel >= 0) ? 16'(dsel) : 16'($urandom);
        nxt_d = srv ? d : 16'($urandom);
        if (req) exp_q.push_back(srv ? d[11:2] : 10'd0);
        #1 chk("rd", rd, srv);
        if (pre == 1) begin m_n = 0; m_uf = 0; end
        if (acc) m_n++;
        if (ufs) m_uf = 1;
        m_mode = fs ? 1 : pre == 1 ? 2 : pre == 2 ? (empty ? 2 : 3) :
                 (pre == 3 && m_n == H * V) ? 4 : pre;
        @(posedge clk); #1;
        chk("rd_load", rd_load, m_mode == 1);
        chk("pix_x", pix_x, (m_n % (H * V)) % H);
        chk("pix_y", pix_y, (m_n % (H * V)) / H);
        chk("underflow", underflow, m_uf);
    endtask

    task automatic do_reset();
        rst_n = 0; vga_req = 0; frame_start = 0; rd_empty = 1;
        exp_q.delete();
        m_mode = 0; m_n = 0; m_uf = 0;
        #1;
        chk("rst_rd_load", rd_load, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_vga", {vga_r, vga_g, vga_b}, 0);
        chk("rst_pix_xy", {pix_x, pix_y}, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_rd", rd, 0);
        chk("rd_addr", rd_addr, 0);
        chk("rd_max_addr", rd_max_addr, H * V);
        chk("rd_length", rd_length, 128);
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic new_frame(bit fill_empty);
        cycle(0, 1, 0, -1);
        cycle(0, 0, 0, -1);
        cycle(0, 0, fill_empty, -1);
    endtask

    initial begin
        #2 do_reset();
        // single pixel from a fresh frame
        new_frame(0);
        cycle(1, 0, 0, 'h0ABC);
        repeat (3) cycle(0, 0, 0, -1);
        // whole frame of ramp data, then a request after completion
        new_frame(0);
        for (int i = 0; i < H * V; i++) cycle(1, 0, 0, i << 2);
        cycle(1, 0, 0, -1);
        repeat (3) cycle(0, 0, 0, -1);
        // empty FIFO on the third request of a line
        new_frame(0);
        cycle(1, 0, 0, -1);
        cycle(1, 0, 0, -1);
        cycle(1, 0, 1, -1);
        cycle(1, 0, 0, -1);
        cycle(1, 0, 0, -1);
        // frame_start with a request while streaming
        cycle(1, 0, 0, -1);
        cycle(1, 1, 0, -1);
        repeat (3) cycle(0, 0, 0, -1);
        // reset between back-to-back requests
        cycle(1, 0, 0, -1);
        cycle(1, 0, 0, -1);
        do_reset();
        repeat (5) cycle(0, 0, 0, -1);
        // request while still waiting for FIFO data
        cycle(0, 1, 0, -1);
        cycle(0, 0, 0, -1);
        cycle(1, 0, 1, -1);
        cycle(0, 0, 1, -1);
        repeat (3) cycle(0, 0, 0, -1);
        // random traffic
        repeat (3000) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 6) == 0, -1);
        end
        repeat (4) cycle(0, 0, 0, -1);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gray_frame_reader.md
# gray_frame_reader

Read-side counterpart of the grayscale capture path. It streams one grayscale frame per display frame out of the SDRAM read FIFO, port RD1. It tracks the raster position and drives replicated 10-bit R/G/B to the VGA controller. The block sits between the SDRAM controller read port and the VGA controller, mirroring the WR1/WR2 write side fed by the image-processing stage.

## Interface
Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- ADDR_W, 23, SDRAM word-address width
- BASE_ADDR, 0, frame start address in SDRAM
- BURST_LEN, 8'd128, read burst length (1..255)

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of VGA vertical blanking
- vga_req  in  1  pixel request from VGA controller (active area only)
- rd_data  in  16  SDRAM read FIFO output; gray value in [11:0], [15:12] ignored
- rd_empty  in  1  read FIFO empty
- rd  out  1  read FIFO request
- rd_load  out  1  FIFO clear / address reload pulse
- rd_addr  out  ADDR_W  read start address
- rd_max_addr  out  ADDR_W  read max address
- rd_length  out  8  read burst length
- vga_r, vga_g, vga_b  out  10 each  pixel colour
- pix_valid  out  1  vga_r/g/b carry a requested pixel
- pix_x  out  11  column of the current accepted request
- pix_y  out  10  row of the current accepted request
- underflow  out  1  sticky: a request could not be served this frame

## Operation
- The state machine has four states: IDLE, LOAD, FILL and ACTIVE, plus DONE.
  - Reset state is IDLE.
  - Any state goes to LOAD on frame_start, and frame_start has priority over everything.
  - LOAD lasts 1 cycle and asserts rd_load. It also clears pix_x, pix_y and underflow.
  - LOAD goes to FILL.
  - FILL goes to ACTIVE on the first cycle with !rd_empty.
  - ACTIVE goes to DONE on the accepted request at x = H_ACT-1, y = V_ACT-1.
  - DONE waits for frame_start.
- Accept: an accept is vga_req in ACTIVE without frame_start.
  - On accept, rd = !rd_empty (combinational) and the raster counter advances.
  - x increments; at H_ACT-1, x wraps to 0 and y increments.
- Underflow: an accept with rd_empty = 1, or vga_req in FILL.
  - The block outputs a black pixel (0,0,0) with pix_valid = 1 and sets underflow.
  - In ACTIVE the counter still advances, keeping the raster aligned. In FILL the counter does not advance.
- vga_req in IDLE, LOAD or DONE: no rd, no counter advance, a black pixel with pix_valid = 1, and no flag.
- Colour: gray[11:2] is driven on all three channels. Truncate, no rounding.
- rd_addr = BASE_ADDR, rd_max_addr = BASE_ADDR + H_ACT*V_ACT, rd_length = BURST_LEN. All three are constants held from reset.

## Timing
- Cycle t: vga_req sampled, rd asserted combinationally. Cycle t+1: rd_data valid. Edge ending t+1: vga_r/g/b and pix_valid registered, so they are visible in cycle t+2.
  - Latency from request to pixel is 2 cycles.
  - Back-to-back requests give one pixel per cycle.
- Black-pixel responses (underflow, idle states) use the same 2-cycle latency. The pipeline carries a "serve-from-FIFO" bit alongside the request.
- pix_x/pix_y are registered, and update the cycle after an accept.
- rd_load is registered, high exactly one cycle (the LOAD cycle).
- Reset values:
  - state IDLE
  - rd 0, rd_load 0
  - vga_r/g/b 0, pix_valid 0
  - pix_x 0, pix_y 0, underflow 0
  - rd_addr/rd_max_addr/rd_length at their constant values
- Reset mid-frame flushes the 2-stage pixel pipeline immediately, with no pixel emitted after rst_n rises.
- frame_start mid-ACTIVE:
  - Pixels already in the pipeline still emerge.
  - No new rd is issued that cycle.
  - Counters are cleared in LOAD.

## Structure
- Shared package img_pkg holds:
  - state enum rd_state_t {IDLE, LOAD, FILL, ACTIVE, DONE}
  - constants GRAY_W = 12 and VGA_W = 10
- One sub-module, raster_counter:
  - inputs clk, rst_n, clr, adv
  - outputs x, y, last (last = x==H_ACT-1 && y==V_ACT-1)
  - parameterised by H_ACT and V_ACT

## Test plan
- Reset, frame_start, rd_empty = 0, rd_data = 16'h0ABC, single vga_req -> rd_load high one cycle; then rd the same cycle as vga_req; vga_r/g/b = 10'h2AF two cycles later, pix_valid = 1, underflow = 0.
- H_ACT = 4, V_ACT = 2, 8 continuous requests with ramp data 0..7<<2 -> outputs 0..7 in order; pix_x wraps 3→0 with pix_y 0→1; DONE after the 8th; a 9th request gives black with no rd.
- rd_empty = 1 on the 3rd request of a line -> no rd that cycle; black pixel at t+2; underflow = 1 and stays set; next request shows pix_x = 3.
- frame_start coincident with vga_req in ACTIVE -> no rd; counters return to 0; underflow cleared; earlier in-flight pixels still delivered.
- rst_n low for 1 cycle between two back-to-back requests -> all outputs at reset values; no pixel_valid afterwards until a new frame_start and request.
- vga_req during FILL (rd_empty = 1) -> black pixel, underflow = 1, pix_x unchanged at 0.
